// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone load/store initiator.
//   CTI_CLASSIC / BTE_LINEAR : constant cycle-type and burst-type codes
//   lsu_size_e               : access size encoding on req_size_i
//   wbm_state_e              : initiator FSM state encoding
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUS     = 2'b01,
        ST_BACKOFF = 2'b10,
        ST_RESP    = 2'b11
    } wbm_state_e;

endpackage

// File: rtl/wb_lsu_align.sv
// Byte-lane alignment for the load/store initiator (purely combinational).
//   req_size_i, req_addr_lo_i, req_wdata_i : incoming request fields
//   sel_o       : byte selects for the request
//   wdata_o     : store data replicated across lanes
//   misalign_o  : reserved size or address not aligned to the size
//   rd_size_i, rd_addr_lo_i, rd_unsigned_i : fields captured at accept
//   rd_data_i   : raw bus read data
//   rd_data_o   : selected lanes, sign- or zero-extended
import wb_pkg::*;

module wb_lsu_align (
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_addr_lo_i,
    input  logic        rd_unsigned_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        sel_o      = 4'b0000;
        wdata_o    = req_wdata_i;
        misalign_o = 1'b0;
        case (lsu_size_e'(req_size_i))
            SIZE_BYTE: begin
                sel_o   = 4'b0001 << req_addr_lo_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                sel_o      = 4'b0011 << req_addr_lo_i;
                wdata_o    = {2{req_wdata_i[15:0]}};
                misalign_o = req_addr_lo_i[0];
            end
            SIZE_WORD: begin
                sel_o      = 4'b1111;
                misalign_o = |req_addr_lo_i;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign rd_shifted = rd_data_i >> {rd_addr_lo_i, 3'b000};
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = rd_shifted[15:0];

    always_comb begin
        rd_data_o = rd_data_i;
        case (lsu_size_e'(rd_size_i))
            SIZE_BYTE: rd_data_o = {{24{~rd_unsigned_i & rd_byte[7]}}, rd_byte};
            SIZE_HALF: rd_data_o = {{16{~rd_unsigned_i & rd_half[15]}}, rd_half};
            default:   rd_data_o = rd_data_i;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic-cycle initiator for single-beat core loads/stores.
// Handles lane alignment, load extension, rty reissue with a one-cycle
// backoff, and a timeout abort; exactly one response per accepted request.
//   wb_clk_i, wb_rst_ni         : clock, async active-low reset
//   req_*                       : core request (valid/ready handshake)
//   rsp_valid_o/rdata_o/err_o   : one-cycle response strobe
//   wbm_*                       : Wishbone master port
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a request
// ST_BUS     | cyc/stb high, waiting for ack/err/rty or timeout
// ST_BACKOFF | one idle bus cycle between an rty and the reissue
// ST_RESP    | rsp_valid_o high for this cycle
import wb_pkg::*;

module wb_lsu_master #(
    parameter int TIMEOUT_CYCLES = 255,   // 1..65535
    parameter int MAX_RETRIES    = 3      // 0..255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    // Counter holds cycles already spent in BUS; abort on the edge that
    // completes the TIMEOUT_CYCLES-th one.
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

    wbm_state_e  state_q, state_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [3:0]  align_sel;
    logic [31:0] align_wdata;
    logic        align_misalign;
    logic [31:0] align_rdata;

    wb_lsu_align u_align (
        .req_size_i    (req_size_i),
        .req_addr_lo_i (req_addr_i[1:0]),
        .req_wdata_i   (req_wdata_i),
        .sel_o         (align_sel),
        .wdata_o       (align_wdata),
        .misalign_o    (align_misalign),
        .rd_size_i     (size_q),
        .rd_addr_lo_i  (addr_lo_q),
        .rd_unsigned_i (uns_q),
        .rd_data_i     (wbm_dat_i),
        .rd_data_o     (align_rdata)
    );

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_lo_d   = addr_lo_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    size_d    = req_size_i;
                    uns_d     = req_unsigned_i;
                    addr_lo_d = req_addr_i[1:0];
                    if (align_misalign) begin
                        // Rejected without touching the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_BUS;
                        we_d        = req_we_i;
                        adr_d       = {req_addr_i[31:2], 2'b00};
                        dat_d       = align_wdata;
                        sel_d       = align_sel;
                        cyc_d       = 1'b1;
                        stb_d       = 1'b1;
                        retry_cnt_d = 8'd0;
                        tmo_cnt_d   = 16'd0;
                    end
                end
            end

            ST_BUS: begin
                if (wbm_ack_i) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : align_rdata;
                end else if (wbm_err_i) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (wbm_rty_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (retry_cnt_q < RETRY_LIMIT) begin
                        state_d     = ST_BACKOFF;
                        retry_cnt_d = retry_cnt_q + 8'd1;
                    end else begin
                        state_d     = ST_RESP;
                        we_d        = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            ST_BACKOFF: begin
                // Reissue with the address/data/sel still held in the flops.
                state_d   = ST_BUS;
                cyc_d     = 1'b1;
                stb_d     = 1'b1;
                tmo_cnt_d = 16'd0;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            retry_cnt_q <= 8'd0;
            tmo_cnt_q   <= 16'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            sel_q       <= 4'b0000;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_lo_q   <= addr_lo_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Held low during reset even though the state is already IDLE.
    assign req_ready_o = (state_q == ST_IDLE) && wb_rst_ni;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_cti_o   = CTI_CLASSIC;
    assign wbm_bte_o   = BTE_LINEAR;

endmodule

// File: tb/tb_wb_lsu_master.sv
module tb_wb_lsu_master;

    localparam int T    = 8;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_uns;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel;
    logic        wbm_we, wbm_cyc, wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic        wbm_ack, wbm_err, wbm_rty;

    always #5 clk = ~clk;

    wb_lsu_master #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(MAXR)) dut (
        .wb_clk_i       (clk),
        .wb_rst_ni      (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .wbm_adr_o      (wbm_adr),
        .wbm_dat_o      (wbm_dat_o),
        .wbm_sel_o      (wbm_sel),
        .wbm_we_o       (wbm_we),
        .wbm_cyc_o      (wbm_cyc),
        .wbm_stb_o      (wbm_stb),
        .wbm_cti_o      (wbm_cti),
        .wbm_bte_o      (wbm_bte),
        .wbm_dat_i      (wbm_dat_i),
        .wbm_ack_i      (wbm_ack),
        .wbm_err_i      (wbm_err),
        .wbm_rty_i      (wbm_rty)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Slave script: per attempt, wait cycles before responding and the
    // response code (0 ack, 1 err, 2 rty, 3 none, 4 ack+err+rty, 5 err+rty).
    int sw[$];
    int so[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        v = d >> (int'(lane) * 8);
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] lane, input logic [1:0] size);
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_dat(input logic [31:0] w, input logic [1:0] size);
        if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic uns, input logic [31:0] rd);
        bit          mis, done, seen, prev;
        int          tot, retries, exp_c, exp_att, a, hc, rises;
        logic        exp_err;
        logic [31:0] exp_data;

        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        exp_err = 1'b0; exp_data = 32'h0; tot = 0; retries = 0; exp_att = 0; exp_c = 1;
        if (mis) begin
            exp_err = 1'b1;
        end else begin
            done = 1'b0;
            for (int k = 0; k < sw.size() && !done; k++) begin
                exp_att++;
                if (so[k] == 3 || sw[k] >= T) begin
                    tot += T; exp_err = 1'b1; done = 1'b1;
                end else begin
                    tot += sw[k] + 1;
                    if (so[k] == 0 || so[k] == 4) begin
                        done = 1'b1;
                        exp_data = we ? 32'h0 : ref_load(rd, addr[1:0], size, uns);
                    end else if (so[k] == 1 || so[k] == 5) begin
                        done = 1'b1; exp_err = 1'b1;
                    end else if (retries < MAXR) begin
                        retries++; tot += 1;
                    end else begin
                        done = 1'b1; exp_err = 1'b1;
                    end
                end
            end
            exp_c = tot + 1;
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        req_size = size; req_uns = uns; wbm_dat_i = rd;
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        a = 0; hc = 0; rises = 0; prev = 1'b0; seen = 1'b0;
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(negedge clk);
            wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0;
            if (rsp_valid) begin
                seen = 1'b1;
                check("rsp_cycle", 32'(c), 32'(exp_c));
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("rsp_rdata", rsp_rdata, exp_data);
                check("cyc_at_rsp", 32'(wbm_cyc), 32'd0);
                check("attempts", 32'(rises), 32'(exp_att));
            end else begin
                if (wbm_cyc) begin
                    if (!prev) rises++;
                    hc++;
                    check("stb", 32'(wbm_stb), 32'd1);
                    check("adr", wbm_adr, {addr[31:2], 2'b00});
                    check("sel", 32'(wbm_sel), 32'(ref_sel(addr[1:0], size)));
                    check("dat_o", wbm_dat_o, ref_dat(wd, size));
                    check("we", 32'(wbm_we), 32'(we));
                    if (a < sw.size() && so[a] != 3 && hc == sw[a] + 1) begin
                        case (so[a])
                            0: wbm_ack = 1'b1;
                            1: wbm_err = 1'b1;
                            2: wbm_rty = 1'b1;
                            4: begin wbm_ack = 1'b1; wbm_err = 1'b1; wbm_rty = 1'b1; end
                            default: begin wbm_err = 1'b1; wbm_rty = 1'b1; end
                        endcase
                        a++; hc = 0;
                    end
                end else begin
                    check("stb_low", 32'(wbm_stb), 32'd0);
                end
                prev = wbm_cyc;
            end
        end
        if (!seen) check("rsp_seen", 32'd0, 32'd1);
        @(negedge clk);
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0;
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    int term_tbl[7] = '{0, 0, 0, 1, 3, 4, 5};

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          nr;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_uns = 1'b0; wbm_dat_i = 32'h0;
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_cyc", 32'(wbm_cyc), 32'd0);
        check("rst_stb", 32'(wbm_stb), 32'd0);
        check("rst_sel", 32'(wbm_sel), 32'd0);
        check("rst_adr", wbm_adr, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("cti", 32'(wbm_cti), 32'd0);
        check("bte", 32'(wbm_bte), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);

        sw = '{1};          so = '{0};          run_req(1'b1, 32'h2000_0104, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0);
        sw = '{0};          so = '{0};          run_req(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80FF_FF7F);
        sw = '{2};          so = '{0};          run_req(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h80FF_FF7F);
        sw = '{0};          so = '{0};          run_req(1'b0, 32'h8000_0001, 32'h0, 2'd1, 1'b0, 32'h1234_5678);
        sw = '{0, 1, 0, 0}; so = '{2, 2, 2, 0}; run_req(1'b0, 32'h0000_0042, 32'h0, 2'd1, 1'b0, 32'h9876_5432);
        sw = '{0, 0, 0, 0}; so = '{2, 2, 2, 2}; run_req(1'b1, 32'h0000_0040, 32'h1111_2222, 2'd2, 1'b0, 32'h0);
        sw = '{0};          so = '{3};          run_req(1'b0, 32'h0000_0080, 32'h0, 2'd2, 1'b0, 32'hAAAA_5555);
        sw = '{T - 1};      so = '{0};          run_req(1'b0, 32'h0000_0084, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D);
        sw = '{T};          so = '{0};          run_req(1'b0, 32'h0000_0088, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D);
        sw = '{0};          so = '{4};          run_req(1'b0, 32'h0000_0012, 32'h0, 2'd1, 1'b0, 32'h8001_0203);
        sw = '{0};          so = '{0};          run_req(1'b0, 32'h0000_0010, 32'h0, 2'd3, 1'b0, 32'h0);

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100; req_size = 2'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("cyc_before_rst", 32'(wbm_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_cyc", 32'(wbm_cyc), 32'd0);
        check("async_stb", 32'(wbm_stb), 32'd0);
        check("async_sel", 32'(wbm_sel), 32'd0);
        check("async_adr", wbm_adr, 32'h0);
        check("async_ready", 32'(req_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_in_rst", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        sw = '{1}; so = '{0};
        run_req(1'b0, 32'h0000_0200, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D);

        for (int i = 0; i < 200; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            sw.delete(); so.delete();
            nr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            for (int j = 0; j < nr; j++) begin
                sw.push_back(int'($urandom_range(0, 3)));
                so.push_back(2);
            end
            sw.push_back(int'($urandom_range(0, 9)));
            so.push_back(term_tbl[$urandom_range(0, 6)]);
            run_req(1'($urandom_range(0, 1)), ad, $urandom, sz, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
